// File: rtl/stage_sequencer.sv
// Generic N-stage one-hot enable sequencer with a variable last stage, stall hold,
// stop-bit halt and saturating performance counters.
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int SW         = $clog2(NUM_STAGES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  stall,
  input  logic [SW-1:0]         last_stage,
  input  logic                  stop_bit,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [SW-1:0]         current_stage,
  output logic                  busy,
  output logic                  instr_done,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam logic [SW-1:0] LAST_IDX   = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0] DECODE_IDX = SW'(1);

  state_t               state_q, state_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [SW-1:0]        lim_q, lim_d, lim_eff;
  logic                 stp_q, stp_d, stp_eff;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] icnt_q, icnt_d;

  // Stage 0 can never be the last stage, and indices past the pipeline map to its end.
  function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
    if (s == '0)            return DECODE_IDX;
    else if (s > LAST_IDX)  return LAST_IDX;
    else                    return s;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      lim_q   <= DECODE_IDX;
      stp_q   <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      lim_q   <= lim_d;
      stp_q   <= stp_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lim_d   = lim_q;
    stp_d   = stp_q;
    done_d  = 1'b0;
    cyc_d   = cyc_q;
    icnt_d  = icnt_q;
    lim_eff = lim_q;
    stp_eff = stp_q;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
          stage_d = '0;
        end
      end
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_WIDTH'(1);
        if (!stall) begin
          // Decode completion: the freshly latched limit applies to this very stage.
          if (stage_q == DECODE_IDX) begin
            lim_eff = clamp_stage(last_stage);
            stp_eff = stop_bit;
            lim_d   = lim_eff;
            stp_d   = stp_eff;
          end
          if (stage_q == lim_eff) begin
            done_d  = 1'b1;
            stage_d = '0;
            if (icnt_q != '1) icnt_d = icnt_q + CNT_WIDTH'(1);
            if (stp_eff)      state_d = HALTED;
            else if (run)     state_d = RUN;
            else              state_d = IDLE;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    busy          = (state_q == RUN);
    halted        = (state_q == HALTED);
    stage_en      = busy ? (NUM_STAGES'(1) << stage_q) : '0;
    current_stage = busy ? stage_q : '0;
    instr_done    = done_q;
    cycle_count   = cyc_q;
    instr_count   = icnt_q;
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: cycle-by-cycle vector table plus
// hand-written run-drop, stop-bit, async-reset and counter-saturation sequences.
module tb_stage_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, stall = 1'b0, stop_bit = 1'b0;
  logic [2:0] last_stage = 3'd0;

  logic [4:0]  stage_en;
  logic [2:0]  current_stage;
  logic        busy, instr_done, halted;
  logic [31:0] cycle_count, instr_count;

  logic       reset_s = 1'b1, run_s = 1'b0;
  logic [2:0] last_stage_s = 3'd1;
  logic [4:0] s_stage_en;
  logic [2:0] s_current_stage;
  logic       s_busy, s_instr_done, s_halted;
  logic [3:0] s_cycle_count, s_instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  stage_sequencer #(.NUM_STAGES(5), .CNT_WIDTH(32)) u_dut (
    .clock(clock), .reset(reset), .run(run), .stall(stall),
    .last_stage(last_stage), .stop_bit(stop_bit),
    .stage_en(stage_en), .current_stage(current_stage), .busy(busy),
    .instr_done(instr_done), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  stage_sequencer #(.NUM_STAGES(5), .CNT_WIDTH(4)) u_sat (
    .clock(clock), .reset(reset_s), .run(run_s), .stall(1'b0),
    .last_stage(last_stage_s), .stop_bit(1'b0),
    .stage_en(s_stage_en), .current_stage(s_current_stage), .busy(s_busy),
    .instr_done(s_instr_done), .halted(s_halted),
    .cycle_count(s_cycle_count), .instr_count(s_instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       run;
    logic       stall;
    logic [2:0] ls;
    logic       stp;
    logic       busy;
    logic [2:0] cs;
    logic       done;
    int         cyc;
    int         ic;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic b, input logic [2:0] cs,
                              input logic d, input logic h, input int cyc, input int ic);
    logic [4:0] en;
    en = b ? (5'b00001 << cs) : 5'b00000;
    check({tag, " stage_en"},      32'(stage_en),      32'(en));
    check({tag, " current_stage"}, 32'(current_stage), b ? 32'(cs) : 32'd0);
    check({tag, " busy"},          32'(busy),          32'(b));
    check({tag, " instr_done"},    32'(instr_done),    32'(d));
    check({tag, " halted"},        32'(halted),        32'(h));
    check({tag, " cycle_count"},   cycle_count,        cyc);
    check({tag, " instr_count"},   instr_count,        ic);
  endtask

  task automatic add(input logic r, input logic s, input logic [2:0] ls, input logic stp,
                     input logic b, input logic [2:0] cs, input logic d, input int cyc, input int ic);
    vec_t v;
    v.run = r; v.stall = s; v.ls = ls; v.stp = stp;
    v.busy = b; v.cs = cs; v.done = d; v.cyc = cyc; v.ic = ic;
    vecs.push_back(v);
  endtask

  initial begin
    // Inputs of each row are applied for the cycle before the edge; outputs are
    // those expected just after that edge.
    // Instruction A, last_stage 4: full five-stage pass
    add(1,0,4,0, 1,0,0,  0,0);
    add(1,0,4,0, 1,1,0,  1,0);
    add(1,0,4,0, 1,2,0,  2,0);
    add(1,0,4,0, 1,3,0,  3,0);
    add(1,0,4,0, 1,4,0,  4,0);
    add(1,0,4,0, 1,0,1,  5,1);
    // B, last_stage 2: early termination, back-to-back
    add(1,0,2,0, 1,1,0,  6,1);
    add(1,0,2,0, 1,2,0,  7,1);
    add(1,0,2,0, 1,0,1,  8,2);
    // C, last_stage 4 only on the decode cycle; other cycles carry junk
    add(1,0,1,0, 1,1,0,  9,2);
    add(1,0,4,0, 1,2,0, 10,2);
    add(1,0,1,0, 1,3,0, 11,2);
    add(1,0,0,0, 1,4,0, 12,2);
    add(1,0,2,0, 1,0,1, 13,3);
    // D: stop_bit outside decode is ignored; 3-cycle stall in stage 3
    add(1,0,4,1, 1,1,0, 14,3);
    add(1,0,4,0, 1,2,0, 15,3);
    add(1,0,4,0, 1,3,0, 16,3);
    add(1,1,4,0, 1,3,0, 17,3);
    add(1,1,4,0, 1,3,0, 18,3);
    add(1,1,4,0, 1,3,0, 19,3);
    add(1,0,4,0, 1,4,0, 20,3);
    add(1,0,4,0, 1,0,1, 21,4);
    // stall in stage 0
    add(1,1,4,0, 1,0,0, 22,4);
    // E: last_stage 7 clamps to 4
    add(1,0,7,0, 1,1,0, 23,4);
    add(1,0,7,0, 1,2,0, 24,4);
    add(1,0,7,0, 1,3,0, 25,4);
    add(1,0,7,0, 1,4,0, 26,4);
    add(1,0,7,0, 1,0,1, 27,5);
    // F: last_stage 0 clamps to 1, retires after decode
    add(1,0,0,0, 1,1,0, 28,5);
    add(1,0,0,0, 1,0,1, 29,6);
    // G: stall on the retiring stage; stop_bit while stalled is ignored
    add(1,0,1,0, 1,1,0, 30,6);
    add(1,1,1,1, 1,1,0, 31,6);
    add(1,0,1,0, 1,0,1, 32,7);

    // Reset state, checked before any clock edge
    #2;
    expect_state("reset", 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    expect_state("idle", 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      run = vecs[i].run; stall = vecs[i].stall;
      last_stage = vecs[i].ls; stop_bit = vecs[i].stp;
      step();
      expect_state($sformatf("vec%0d", i), vecs[i].busy, vecs[i].cs, vecs[i].done,
                   1'b0, vecs[i].cyc, vecs[i].ic);
    end

    // Run drop in stage 2 of a last_stage 4 instruction
    run = 1'b1; stall = 1'b0; stop_bit = 1'b0; last_stage = 3'd4;
    step(); expect_state("drop s1", 1, 1, 0, 0, 33, 7);
    step(); expect_state("drop s2", 1, 2, 0, 0, 34, 7);
    run = 1'b0;
    step(); expect_state("drop s3", 1, 3, 0, 0, 35, 7);
    step(); expect_state("drop s4", 1, 4, 0, 0, 36, 7);
    step(); expect_state("drop retire", 0, 0, 1, 0, 37, 8);
    step(); expect_state("drop idle", 0, 0, 0, 0, 37, 8);

    // Stop bit on the third instruction
    reset = 1'b1;
    #1;
    expect_state("reset2", 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    run = 1'b1; last_stage = 3'd1;
    step(); expect_state("stop i1 s0", 1, 0, 0, 0, 0, 0);
    step(); expect_state("stop i1 s1", 1, 1, 0, 0, 1, 0);
    step(); expect_state("stop i2 s0", 1, 0, 1, 0, 2, 1);
    step(); expect_state("stop i2 s1", 1, 1, 0, 0, 3, 1);
    step(); expect_state("stop i3 s0", 1, 0, 1, 0, 4, 2);
    step(); expect_state("stop i3 s1", 1, 1, 0, 0, 5, 2);
    stop_bit = 1'b1;
    step(); expect_state("stop retire", 0, 0, 1, 1, 6, 3);
    stop_bit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      stall = 1'($urandom_range(0, 1));
      last_stage = 3'($urandom_range(0, 7));
      step();
      expect_state($sformatf("halted hold %0d", k), 0, 0, 0, 1, 6, 3);
    end
    stall = 1'b0;

    // Asynchronous reset during stage 3
    reset = 1'b1;
    step();
    reset = 1'b0;
    run = 1'b1; last_stage = 3'd4;
    step(); step(); step();
    step(); expect_state("pre-reset s3", 1, 3, 0, 0, 3, 0);
    #2;
    reset = 1'b1;
    #1;
    expect_state("async reset", 0, 0, 0, 0, 0, 0);
    step();
    expect_state("reset held", 0, 0, 0, 0, 0, 0);
    run = 1'b0;
    reset = 1'b0;

    // Saturation with 4-bit counters, two-cycle instructions
    reset_s = 1'b0;
    run_s = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      int ec, ei;
      step();
      ec = (k - 1 > 15) ? 15 : k - 1;
      ei = ((k - 1) / 2 > 15) ? 15 : (k - 1) / 2;
      check($sformatf("sat cycle_count k=%0d", k), 32'(s_cycle_count), ec);
      check($sformatf("sat instr_count k=%0d", k), 32'(s_instr_count), ei);
    end
    check("sat busy", 32'(s_busy), 32'd1);
    run_s = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
